// File: rtl/norm_issuer.sv
// Initiator side of the normalizer interface: buffers psum vectors, launches them one at a
// time on a rising-edge valid, waits out div_complete, and presents the result downstream.
module norm_issuer #(
   parameter int bw         = 8,
   parameter int bw_psum    = 2*bw+4,
   parameter int col        = 8,
   parameter int DEPTH      = 4,
   parameter int VALID_HOLD = 2,
   parameter int SETTLE     = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [bw_psum*col-1:0]       in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [bw_psum*col-1:0]       norm_in,
   output logic                         norm_valid,
   input  logic                         norm_div_complete,
   input  logic [bw_psum*col-1:0]       norm_out,
   output logic [bw_psum*col-1:0]       out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic [$clog2(DEPTH):0]       fifo_level,
   output logic [2:0]                   state_dbg
);

   localparam int W    = bw_psum*col;
   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW+1;
   localparam int CMAX = (VALID_HOLD > SETTLE) ? VALID_HOLD : SETTLE;
   localparam int CW   = $clog2(CMAX+1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(VALID_HOLD-1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE-1);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LAUNCH     = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_DONE  = 3'd3,
      S_SETTLE     = 3'd4,
      S_OUTPUT     = 3'd5
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            push;
   logic            pop;

   // Both sides use valid/ready: a transfer happens on a rising clk edge where valid and
   // ready are both high; valid and data hold steady until then.
   assign in_ready = (fifo_level != LW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = (state == S_IDLE) && (fifo_level != '0) && !out_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:       if (pop)                state_nxt = S_LAUNCH;
         S_LAUNCH:     if (cnt == HOLD_LAST)   state_nxt = S_WAIT_START;
         S_WAIT_START: if (!norm_div_complete) state_nxt = S_WAIT_DONE;
         S_WAIT_DONE:  if (norm_div_complete)  state_nxt = S_SETTLE;
         S_SETTLE:     if (cnt == SETTLE_LAST) state_nxt = S_OUTPUT;
         S_OUTPUT:     if (out_ready)          state_nxt = S_IDLE;
         default:                              state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      norm_valid = (state == S_LAUNCH);
      busy       = (state != S_IDLE);
      state_dbg  = state;
   end

   // Per-state cycle counter, restarted on every state change.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                cnt <= '0;
      else if (state_nxt != state) cnt <= '0;
      else                         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         norm_in    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            norm_in <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Capture in the last settle cycle so the normalizer output has had SETTLE cycles to resolve.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (state == S_SETTLE && cnt == SETTLE_LAST) begin
         out_data  <= norm_out;
         out_valid <= 1'b1;
      end else if (state == S_OUTPUT && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_norm_issuer.sv
// Bench for norm_issuer with a behavioural normalizer (lane*256/sum|lanes|) and a scoreboard.
module tb_norm_issuer;
   localparam int BP  = 20;
   localparam int COL = 8;
   localparam int W   = BP*COL;
   localparam int NORM_LAT = 6;

   logic           clk;
   logic           reset_n;
   logic [W-1:0]   in_data;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   norm_in;
   logic           norm_valid;
   logic           norm_div_complete;
   logic [W-1:0]   norm_out;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic           busy;
   logic [2:0]     fifo_level;
   logic [2:0]     state_dbg;

   logic [W-1:0]   exp_q[$];
   logic [W-1:0]   exp_in_q[$];
   int errors = 0;
   int checks = 0;
   int launches = 0;
   int outs = 0;

   norm_issuer dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .norm_in(norm_in), .norm_valid(norm_valid),
      .norm_div_complete(norm_div_complete), .norm_out(norm_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .fifo_level(fifo_level), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] normalize(input logic [W-1:0] v);
      logic signed [BP-1:0] t;
      int s;
      int lane;
      logic [W-1:0] r;
      r = '0;
      s = 0;
      for (int k = 0; k < COL; k++) begin
         t = v[k*BP +: BP];
         lane = int'(t);
         s += (lane < 0) ? -lane : lane;
      end
      if (s == 0) return '0;
      for (int k = 0; k < COL; k++) begin
         t = v[k*BP +: BP];
         lane = int'(t);
         r[k*BP +: BP] = BP'((lane * 256) / s);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      int x;
      v = '0;
      for (int k = 0; k < COL; k++) begin
         x = int'($urandom_range(100)) - 50;
         v[k*BP +: BP] = BP'(x);
      end
      return v;
   endfunction

   // ---------------- normalizer model ----------------
   logic         nv_q;
   int           lat;
   logic [W-1:0] held;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nv_q <= 1'b0;
         norm_div_complete <= 1'b1;
         lat <= 0;
         held <= '0;
         norm_out <= '0;
      end else begin
         nv_q <= norm_valid;
         if (norm_valid && !nv_q) begin
            norm_div_complete <= 1'b0;
            lat <= NORM_LAT;
            held <= norm_in;
         end else if (lat > 1) begin
            lat <= lat - 1;
         end else if (lat == 1) begin
            lat <= 0;
            norm_out <= normalize(held);
            norm_div_complete <= 1'b1;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic prev_nv = 1'b0;
   int   width = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_nv = 1'b0;
         width = 0;
      end else begin
         if (norm_valid) begin
            if (!prev_nv) begin
               launches++;
               if (exp_in_q.size() > 0) chk("norm_in", norm_in, exp_in_q.pop_front());
               else chk("norm_in_unexpected", 1, 0);
            end
            width++;
         end else if (prev_nv) begin
            chk("nv_width", width, 2);
            width = 0;
         end
         prev_nv = norm_valid;
         if (out_valid && out_ready) begin
            outs++;
            if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
            else chk("out_unexpected", 1, 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push(input logic [W-1:0] v);
      int n = 0;
      in_data = v;
      in_valid = 1'b1;
      while (!in_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("push_timeout", 0, 1);
      end else begin
         exp_q.push_back(normalize(v));
         exp_in_q.push_back(v);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n = 0;
      while (!out_valid && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) chk("wait_out_valid_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || fifo_level != 0 || out_valid) && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_idle", {busy, fifo_level, out_valid}, 0);
   endtask

   // ---------------- stimulus ----------------
   logic [W-1:0] v;
   logic [W-1:0] vb;
   logic [W-1:0] d0;
   int l0;
   int o0;
   bit changed;

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_level", fifo_level, 0);
      chk("rst_busy", busy, 0);
      chk("rst_norm_valid", norm_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      #22 reset_n = 1'b1;
      @(posedge clk); #1;

      // Ones vector
      out_ready = 1'b1;
      l0 = launches; o0 = outs;
      v = '0;
      for (int k = 0; k < COL; k++) v[k*BP +: BP] = BP'(1);
      push(v);
      wait_out_valid();
      for (int k = 0; k < COL; k++) chk("ones_lane", out_data[k*BP +: BP], 32);
      drain();
      chk("ones_launches", launches - l0, 1);
      chk("ones_outs", outs - o0, 1);

      // Signed mix
      v = '0;
      v[0 +: BP] = BP'(4);
      v[BP +: BP] = BP'(-4);
      push(v);
      wait_out_valid();
      chk("mix_lane0", out_data[0 +: BP], 20'd128);
      chk("mix_lane1", out_data[BP +: BP], 20'hFFF80);
      chk("mix_rest", out_data[W-1:2*BP], 0);
      drain();

      // Backpressure
      out_ready = 1'b0;
      push(rand_vec());
      push(rand_vec());
      wait_out_valid();
      l0 = launches;
      d0 = out_data;
      changed = 1'b0;
      repeat (50) begin
         @(posedge clk); #1;
         if (out_data !== d0 || !out_valid) changed = 1'b1;
      end
      chk("bp_stable", changed, 0);
      chk("bp_no_launch", launches - l0, 0);
      out_ready = 1'b1;
      drain();
      chk("bp_one_launch", launches - l0, 1);

      // FIFO full
      out_ready = 1'b0;
      o0 = outs;
      for (int i = 0; i < 5; i++) push(rand_vec());
      chk("full_level", fifo_level, 4);
      chk("full_in_ready", in_ready, 0);
      out_ready = 1'b1;
      push(rand_vec());
      drain();
      chk("full_outs", outs - o0, 6);

      // Simultaneous push/pop
      out_ready = 1'b0;
      push(rand_vec());
      wait_out_valid();
      vb = rand_vec();
      push(vb);
      chk("sim_level_pre", fifo_level, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("sim_idle", busy, 0);
      push(rand_vec());
      chk("sim_level_post", fifo_level, 1);
      chk("sim_launch", busy, 1);
      chk("sim_older", norm_in, vb);
      drain();

      // Async reset mid WAIT_DONE
      push(rand_vec());
      begin
         int n = 0;
         while (state_dbg != 3'd3 && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("rst_reached_wait_done", state_dbg, 3'd3);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_level", fifo_level, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_norm_valid", norm_valid, 0);
      chk("arst_norm_in", norm_in, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", out_data, 0);
      exp_q.delete();
      exp_in_q.delete();
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      l0 = launches; o0 = outs;
      push(rand_vec());
      drain();
      chk("post_rst_launch", launches - l0, 1);
      chk("post_rst_out", outs - o0, 1);

      // Random traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               push(rand_vec());
               repeat ($urandom_range(3)) begin @(posedge clk); #1; end
            end
         end
         begin
            repeat (300) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(1));
            end
         end
      join
      out_ready = 1'b1;
      drain();
      chk("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
